// File: rtl/dmg_dma_pkg.sv
// Shared definitions for the OAM DMA engine: state encoding, register map and source paging.
package dmg_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_ACTIVE = 2'd2
  } dma_state_e;

  localparam logic [15:0] DMA_REG_ADR = 16'hFF46;
  localparam int unsigned DMA_LEN     = 160;
  localparam logic [15:0] IO_BASE     = 16'hFF00;

  // Sources in E0..FF alias onto C0..DF (echo RAM mapping).
  function automatic logic [7:0] src_page(input logic [7:0] s);
    return (s >= 8'hE0) ? 8'(s - 8'h20) : s;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: copies LEN bytes from {src,00} to OAM, one byte per M-cycle,
// arbitrating the external bus between the CPU and the transfer.
module oam_dma
  import dmg_dma_pkg::*;
#(
  parameter logic [15:0] REG_ADR = DMA_REG_ADR,
  parameter int unsigned LEN     = DMA_LEN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        t4,
  input  logic [15:0] cpu_adr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic [15:0] ext_adr,
  output logic [7:0]  ext_dout,
  output logic        ext_rd,
  output logic        ext_wr,
  input  logic [7:0]  ext_din,
  output logic [7:0]  oam_adr,
  output logic [7:0]  oam_dout,
  output logic        oam_wr,
  output logic        dma_active
);

  localparam logic [7:0] IDX_LAST = 8'(LEN - 1);

  dma_state_e state, state_nxt;
  logic [7:0] idx, idx_nxt;
  logic [7:0] src;
  logic [7:0] pend_data;
  logic       pending;
  logic       reg_wr;
  logic       go;
  logic       act;

  assign reg_wr = cpu_wr && (cpu_adr == REG_ADR);
  // A register write seen on this t4, or one held since earlier in the M-cycle, starts a transfer.
  assign go     = t4 && (reg_wr || pending);
  // Reset masks the transfer immediately so nothing leaks out during the reset cycle.
  assign act    = (state == ST_ACTIVE) && !reset;

  // State and byte index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      idx   <= 8'h00;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Source register commits on t4; writes landing off t4 are held as pending until then.
  always_ff @(posedge clk) begin
    if (reset) begin
      src       <= 8'h00;
      pending   <= 1'b0;
      pend_data <= 8'h00;
    end else if (go) begin
      src     <= reg_wr ? cpu_dout : pend_data;
      pending <= 1'b0;
    end else if (reg_wr) begin
      pending   <= 1'b1;
      pend_data <= cpu_dout;
    end
  end

  // Next-state logic, advancing only at M-cycle boundaries.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    if (t4) begin
      unique case (state)
        ST_IDLE: begin
          if (go) begin
            state_nxt = ST_START;
            idx_nxt   = 8'h00;
          end
        end
        ST_START: begin
          state_nxt = go ? ST_START : ST_ACTIVE;
          idx_nxt   = 8'h00;
        end
        ST_ACTIVE: begin
          if (go) begin
            state_nxt = ST_START;
            idx_nxt   = 8'h00;
          end else if (idx == IDX_LAST) begin
            state_nxt = ST_IDLE;
            idx_nxt   = 8'h00;
          end else begin
            idx_nxt = 8'(idx + 8'd1);
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          idx_nxt   = 8'h00;
        end
      endcase
    end
  end

  // Bus steering: CPU pass-through normally, DMA owns the external bus while active.
  // High-range CPU accesses during a transfer share the data lines but never assert ext strobes.
  always_comb begin
    ext_adr    = cpu_adr;
    ext_dout   = cpu_dout;
    ext_rd     = cpu_rd;
    ext_wr     = cpu_wr;
    cpu_din    = ext_din;
    oam_wr     = 1'b0;
    oam_adr    = idx;
    oam_dout   = ext_din;
    dma_active = act;
    if (act) begin
      ext_adr = {src_page(src), idx};
      ext_rd  = 1'b1;
      ext_wr  = 1'b0;
      oam_wr  = t4;
      cpu_din = (cpu_adr >= IO_BASE) ? ext_din : 8'hFF;
    end
    if (cpu_adr == REG_ADR) begin
      cpu_din = src;
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Randomized bench for oam_dma against an M-cycle schedule reference model.
module tb_oam_dma;
  import dmg_dma_pkg::*;

  localparam int unsigned LEN = DMA_LEN;
  localparam logic [15:0] REG = DMA_REG_ADR;

  logic        clk = 1'b0;
  logic        reset, t4, cpu_rd, cpu_wr, ext_rd, ext_wr, oam_wr, dma_active;
  logic [15:0] cpu_adr, ext_adr;
  logic [7:0]  cpu_dout, cpu_din, ext_dout, ext_din, oam_adr, oam_dout;

  always #5 clk = ~clk;

  oam_dma dut (
    .clk(clk), .reset(reset), .t4(t4),
    .cpu_adr(cpu_adr), .cpu_dout(cpu_dout), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_din(cpu_din),
    .ext_adr(ext_adr), .ext_dout(ext_dout), .ext_rd(ext_rd), .ext_wr(ext_wr),
    .ext_din(ext_din),
    .oam_adr(oam_adr), .oam_dout(oam_dout), .oam_wr(oam_wr),
    .dma_active(dma_active)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: mc counts t4s since the triggering t4 (0 = START, 1..LEN = transfer).
  int         mc = LEN + 1;
  logic [7:0] m_src = 8'h00;
  logic [7:0] m_pd = 8'h00;
  bit         m_pend = 1'b0;
  int         ph = 0;
  int         pulses = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive, check outputs against the model, advance the model.
  task automatic cyc(input logic rst, input logic wr, input logic rd,
                     input logic [15:0] adr, input logic [7:0] dout);
    logic       act;
    logic       e_oam;
    logic [7:0] sp, id, e_din;
    logic       wr_reg;
    @(negedge clk);
    reset    = rst;
    cpu_wr   = wr;
    cpu_rd   = rd;
    cpu_adr  = adr;
    cpu_dout = dout;
    t4       = (ph == 3);
    ext_din  = 8'($urandom);
    #1;
    act   = (mc >= 1) && (mc <= LEN) && !rst;
    sp    = (m_src >= 8'hE0) ? 8'(m_src - 8'h20) : m_src;
    id    = 8'(mc - 1);
    e_oam = act && t4;
    if (adr == REG)            e_din = m_src;
    else if (!act)             e_din = ext_din;
    else if (adr >= 16'hFF00)  e_din = ext_din;
    else                       e_din = 8'hFF;
    chk("ext_adr", ext_adr, act ? {sp, id} : adr);
    chk("ext_rd", 16'(ext_rd), act ? 16'd1 : 16'(rd));
    chk("ext_wr", 16'(ext_wr), act ? 16'd0 : 16'(wr));
    chk("ext_dout", 16'(ext_dout), 16'(dout));
    chk("cpu_din", 16'(cpu_din), 16'(e_din));
    chk("oam_wr", 16'(oam_wr), 16'(e_oam));
    chk("dma_active", 16'(dma_active), 16'(act));
    if (e_oam) begin
      chk("oam_adr", 16'(oam_adr), 16'(id));
      chk("oam_dout", 16'(oam_dout), 16'(ext_din));
    end
    if (oam_wr === 1'b1) pulses++;
    wr_reg = wr && (adr == REG);
    if (rst) begin
      mc = LEN + 1; m_src = 8'h00; m_pend = 1'b0;
    end else if (ph == 3) begin
      if (wr_reg || m_pend) begin
        m_src = wr_reg ? dout : m_pd; m_pend = 1'b0; mc = 0;
      end else if (mc <= LEN) begin
        mc++;
      end
    end else if (wr_reg) begin
      m_pend = 1'b1; m_pd = dout;
    end
    ph = (ph + 1) % 4;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  // Random CPU traffic; register writes and resets only when allowed.
  task automatic traffic(input bit allow_reg, input bit allow_rst);
    logic        wr, rd, rst;
    logic [15:0] adr;
    int          r;
    wr  = 1'b0; rd = 1'b0;
    adr = 16'($urandom);
    r   = $urandom_range(0, 9);
    case (r)
      3: begin rd = 1'b1; adr = 16'h8000 | 16'($urandom_range(0, 16'h7EFF)); end
      4: begin wr = 1'b1; adr = 16'($urandom_range(0, 16'hFEFF)); end
      5: begin rd = 1'b1; adr = 16'hFF80 | 16'($urandom_range(0, 127)); end
      6: begin wr = 1'b1; adr = 16'hFF80; end
      7: begin rd = 1'b1; adr = REG; end
      8: begin rd = 1'b1; adr = {8'hFF, 8'($urandom)}; end
      default: ;
    endcase
    if (!allow_reg && wr && adr == REG) adr = 16'hFF47;
    if (allow_reg && $urandom_range(0, 799) == 0) begin wr = 1'b1; rd = 1'b0; adr = REG; end
    rst = allow_rst && ($urandom_range(0, 1999) == 0);
    cyc(rst, wr, rd, adr, 8'($urandom));
  endtask

  task automatic run(input int n, input bit allow_reg, input bit allow_rst);
    for (int i = 0; i < n; i++) traffic(allow_reg, allow_rst);
  endtask

  task automatic reg_write(input logic [7:0] d);
    while (ph != 3) idle();
    cyc(1'b0, 1'b1, 1'b0, REG, d);
  endtask

  // Run traffic until the model reaches the t4 cycle of transfer step (target-1).
  task automatic wait_model(input int target);
    int n = 0;
    while (!(mc == target && ph == 3) && n < 2000) begin
      traffic(1'b0, 1'b0);
      n++;
    end
    chk("wait_budget", 16'(n < 2000), 16'd1);
  endtask

  initial begin
    reset = 1'b1; t4 = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    cpu_adr = 16'h0000; cpu_dout = 8'h00; ext_din = 8'h00;

    repeat (3) cyc(1'b1, 1'b0, 1'b1, 16'h1234, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, REG, 8'h00);
    run(20, 1'b0, 1'b0);

    pulses = 0;
    reg_write(8'hC1);
    run(161 * 4 + 8, 1'b0, 1'b0);
    chk("pulses_c1", 16'(pulses), 16'(LEN));

    pulses = 0;
    reg_write(8'hFE);
    run(161 * 4 + 8, 1'b0, 1'b0);
    chk("pulses_fe", 16'(pulses), 16'(LEN));

    reg_write(8'hC1);
    wait_model(51);
    cyc(1'b0, 1'b1, 1'b0, REG, 8'hD0);
    pulses = 0;
    run(161 * 4 + 8, 1'b0, 1'b0);
    chk("pulses_restart", 16'(pulses), 16'(LEN));

    reg_write(8'hC1);
    wait_model(81);
    cyc(1'b1, 1'b0, 1'b1, 16'h8000, 8'h00);
    pulses = 0;
    cyc(1'b0, 1'b0, 1'b1, 16'h8000, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, REG, 8'h00);
    run(700, 1'b0, 1'b0);
    chk("pulses_after_reset", 16'(pulses), 16'd0);

    while (ph != 3) idle();
    cyc(1'b1, 1'b1, 1'b0, REG, 8'h55);
    pulses = 0;
    run(700, 1'b0, 1'b0);
    chk("pulses_rst_wr", 16'(pulses), 16'd0);

    while (ph != 1) idle();
    cyc(1'b0, 1'b1, 1'b0, REG, 8'hE5);
    pulses = 0;
    run(700, 1'b0, 1'b0);
    chk("pulses_pending", 16'(pulses), 16'(LEN));

    run(6000, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL have parameter REG_ADR, default 16'hFF46: address of the DMA source register.
REQ-002 SHALL have parameter LEN, default 160: number of bytes per transfer.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk clocks all state, reset is sampled on the rising edge of clk.
REQ-004 clk  input  1  system clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 t4  input  1  one-clk pulse on the last T-state of every M-cycle.
REQ-007 cpu_adr  input  16  CPU address.
REQ-008 cpu_dout  input  8  CPU write data.
REQ-009 cpu_rd, cpu_wr  input  1 each  CPU read and write strobes.
REQ-010 cpu_din  output  8  read data returned to the CPU.
REQ-011 ext_adr  output  16  address to the external/memory bus.
REQ-012 ext_dout  output  8  write data to the external/memory bus.
REQ-013 ext_rd, ext_wr  output  1 each  external read and write strobes.
REQ-014 ext_din  input  8  read data from the external/memory bus.
REQ-015 oam_adr  output  8  OAM write index.
REQ-016 oam_dout  output  8  OAM write data.
REQ-017 oam_wr  output  1  OAM write strobe, one clk wide.
REQ-018 dma_active  output  1  high while in ACTIVE.

Function
REQ-019 SHALL implement three states: IDLE, START, ACTIVE; idx is an 8-bit counter; src is an 8-bit register.
REQ-020 A CPU write to REG_ADR SHALL load src from cpu_dout on the t4 pulse and set a start-pending flag.
REQ-021 A CPU read of REG_ADR SHALL return src, in every state.
REQ-022 At t4 with start-pending set, the block SHALL enter START and clear the flag; on the next t4 it SHALL enter ACTIVE with idx=0.
REQ-023 In ACTIVE, each M-cycle SHALL drive ext_adr={src',idx} with ext_rd=1.
- src' = src-8'h20 when src>=8'hE0, otherwise src.
REQ-024 In ACTIVE, at t4 of each M-cycle:
- oam_wr=1, oam_adr=idx, oam_dout=ext_din;
- then idx increments.
REQ-025 After the write with idx==LEN-1, the block SHALL return to IDLE; a transfer totals LEN+1 M-cycles (the START cycle plus LEN transfer cycles) from the triggering t4.
REQ-026 A write to REG_ADR during START or ACTIVE SHALL restart: the current transfer continues with the old src until the next t4, then the block enters START; that cycle's oam_wr is still issued.
REQ-027 Outside ACTIVE, the CPU SHALL pass through: ext_adr=cpu_adr, ext_dout=cpu_dout, ext_rd=cpu_rd, ext_wr=cpu_wr, cpu_din=ext_din (REG_ADR reads excepted).
REQ-028 In ACTIVE, CPU accesses with cpu_adr>=16'hFF00 SHALL still be serviced.
- These accesses do not reach the external bus.
- Reads return the matching register value; REG_ADR is the only register internal to this block.
- All other accesses in this range behave as a zero-latency external pass-through on a dedicated IO path.
REQ-029 In ACTIVE, CPU accesses with cpu_adr<16'hFF00 SHALL be blocked: writes are dropped and reads return 8'hFF.
REQ-030 idx SHALL never exceed LEN-1; oam_wr SHALL be low in IDLE and START.

Reset
REQ-031 reset SHALL force IDLE, idx=0, src=8'h00, start-pending=0, dma_active=0, oam_wr=0, ext_rd=cpu_rd, ext_wr=cpu_wr.
REQ-032 reset mid-transfer SHALL abort with no further oam_wr; src is not preserved.
REQ-033 reset SHALL take priority over a simultaneous REG_ADR write.

Structure
REQ-034 The state enum, REG_ADR, LEN and the HRAM/IO base 16'hFF00 SHALL live in a shared package dmg_dma_pkg.
REQ-035 The block SHALL be a single module; no sub-module is warranted.

Verification
REQ-036 Write 8'hC1 to FF46 -> after 1 START M-cycle, 160 oam_wr pulses; ext_adr runs 16'hC100..16'hC19F; oam_adr runs 0..159; dma_active drops after the last pulse.
REQ-037 Write 8'hFE -> ext_adr starts at 16'hDE00.
REQ-038 During ACTIVE: CPU read of 16'h8000 -> 8'hFF; CPU write to 16'hFF80 -> passes; CPU read of FF46 -> current src.
REQ-039 At idx=50, write 8'hD0 -> idx 50 is still written from the old src; then START; then the transfer restarts at 16'hD000 with idx=0.
REQ-040 Assert reset at idx=80 -> IDLE; no oam_wr; src=0; the next CPU access passes through.
REQ-041 Write to FF46 coincident with reset -> no transfer starts.
